// File: rtl/demux_for_8way.sv
// demux_for_8way: 1-to-8 single-bit demultiplexer with optional registered outputs.
// Port names and the active-low async reset are fixed by the block interface.
module demux_for_8way #(
  parameter int REG_OUT = 0,
  parameter int SEL_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i,
  input  logic [SEL_W-1:0] sel,
  output logic             o0,
  output logic             o1,
  output logic             o2,
  output logic             o3,
  output logic             o4,
  output logic             o5,
  output logic             o6,
  output logic             o7
);
  logic [7:0] w_dec;
  logic [7:0] r_dec;
  logic [7:0] w_out;
  // if() rather than ?: so an unknown select falls to the 0 default instead of passing i
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < 8; k++)
      if (sel == SEL_W'(k)) w_dec[k] = i;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_dec <= '0;
    else        r_dec <= w_dec;
  assign w_out = (REG_OUT != 0) ? r_dec : w_dec;
  assign {o7, o6, o5, o4, o3, o2, o1, o0} = w_out;
endmodule

// File: tb/tb_demux_for_8way.sv
// tb_demux_for_8way: directed table-driven checks of the combinational and registered variants.
module tb_demux_for_8way;
  logic clk = 0;
  logic reset;
  logic i;
  logic [2:0] sel;
  logic [7:0] c_o, r_o;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       i;
    logic [2:0] sel;
    logic [7:0] exp;
  } vec_t;
  vec_t v[12];

  always #5 clk = ~clk;

  demux_for_8way #(.REG_OUT(0)) u_comb (
    .clk(clk), .reset(reset), .i(i), .sel(sel),
    .o0(c_o[0]), .o1(c_o[1]), .o2(c_o[2]), .o3(c_o[3]),
    .o4(c_o[4]), .o5(c_o[5]), .o6(c_o[6]), .o7(c_o[7])
  );

  demux_for_8way #(.REG_OUT(1)) u_reg (
    .clk(clk), .reset(reset), .i(i), .sel(sel),
    .o0(r_o[0]), .o1(r_o[1]), .o2(r_o[2]), .o3(r_o[3]),
    .o4(r_o[4]), .o5(r_o[5]), .o6(r_o[6]), .o7(r_o[7])
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{1'b1, 3'd5, 8'b0010_0000};
    v[1]  = '{1'b1, 3'd2, 8'b0000_0100};
    v[2]  = '{1'b0, 3'd2, 8'b0000_0000};
    v[3]  = '{1'b1, 3'd0, 8'b0000_0001};
    v[4]  = '{1'b1, 3'd1, 8'b0000_0010};
    v[5]  = '{1'b1, 3'd3, 8'b0000_1000};
    v[6]  = '{1'b1, 3'd4, 8'b0001_0000};
    v[7]  = '{1'b1, 3'd6, 8'b0100_0000};
    v[8]  = '{1'b1, 3'd7, 8'b1000_0000};
    v[9]  = '{1'b1, 3'd0, 8'b0000_0001};
    v[10] = '{1'b0, 3'd7, 8'b0000_0000};
    v[11] = '{1'b1, 3'd7, 8'b1000_0000};

    reset = 0; i = 0; sel = 0;
    #3;
    chk("reset_state_reg", r_o, 8'h00);
    chk("reset_state_comb", c_o, 8'h00);

    // held in reset with a live select: register stays clear, comb path unaffected
    @(negedge clk); i = 1; sel = 3'd3;
    @(posedge clk); #1;
    chk("in_reset_reg", r_o, 8'h00);
    chk("in_reset_comb", c_o, 8'h08);
    @(negedge clk); reset = 1;
    #1 chk("release_no_capture", r_o, 8'h00);
    @(posedge clk); #1;
    chk("first_capture", r_o, 8'h08);

    // o0 tracks i toggling every 17 ns
    @(negedge clk); sel = 3'd0;
    for (int t = 0; t < 6; t++) begin
      i = t[0];
      #1 chk("track_o0", c_o, {7'b0, i});
      #16;
    end

    // sel change: comb immediately, registered on next edge
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); i = v[n].i; sel = v[n].sel;
      #1 chk($sformatf("tbl_comb[%0d]", n), c_o, v[n].exp);
      @(posedge clk); #1;
      chk($sformatf("tbl_reg[%0d]", n), r_o, v[n].exp);
    end

    // sweep all selects with i toggling, then wrap back to 0
    for (int s = 0; s < 9; s++) begin
      sel = 3'(s);
      for (int t = 0; t < 6; t++) begin
        i = ~t[0];
        #1 chk($sformatf("sweep_s%0d", s), c_o, 8'({7'b0, i} << sel));
        #49;
      end
    end

    // mid-run async reset pulse clears o6 without waiting for clk
    @(negedge clk); i = 1; sel = 3'd6;
    @(posedge clk); #1;
    chk("pre_pulse_o6", r_o, 8'h40);
    #1 reset = 0;
    #1 chk("async_clear", r_o, 8'h00);
    @(posedge clk); #1;
    chk("held_clear", r_o, 8'h00);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    chk("post_pulse_o6", r_o, 8'h40);

    // unknown select: 4-state sims see X and must block; 2-state sims resolve it to a value
    @(negedge clk); i = 1; sel = 3'bx1x;
    #1;
    if ($isunknown(sel)) chk("sel_x_comb", c_o, 8'h00);
    else                 chk("sel_x_comb", c_o, 8'(8'b1 << sel));
    @(posedge clk); #1;
    if ($isunknown(sel)) chk("sel_x_reg", r_o, 8'h00);
    else                 chk("sel_x_reg", r_o, 8'(8'b1 << sel));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
